firmware_config_sequencer: RTL and testbench
============================================

Name: firmware_config_sequencer

Overview:
Sequences firmware reconfiguration of the trace pipeline (vector-vector ALUs and sibling blocks sharing the configId/configData broadcast bus). Host config writes are buffered in a FIFO. On commit, the block drops tracing, waits for in-flight vectors to drain, replays the buffered writes one per cycle on the broadcast bus, then restores tracing. Sits between the host/debug interface and the pipeline's tracing, configId and configData inputs.

Parameters:
FIFO_DEPTH, 16, buffered config writes; power of two, at least 2.
DRAIN_CYCLES, 4, minimum quiet cycles after tracing drops; at least the pipeline latency.
IDLE_ID, 0, configId value meaning "no write"; no block uses it as PERSONAL_CONFIG_ID.

Ports:
clk  in  1  single clock.
rst_n  in  1  reset, asynchronous and active-low.
host_valid  in  1  a config write is offered.
host_ready  out  1  FIFO can accept; a transfer occurs when host_valid and host_ready are both high.
host_config_id  in  8  target block id; IDLE_ID entries are dropped.
host_config_data  in  8  config byte.
host_commit  in  1  pulse; apply buffered writes.
tracing_req  in  1  host wants tracing enabled.
pipe_valid  in  1  OR of valid signals inside the pipeline.
tracing  out  1  drives pipeline tracing.
configId  out  8  broadcast id.
configData  out  8  broadcast data.
busy  out  1  high in every state except IDLE.
commit_done  out  1  one-cycle pulse when a commit finishes.
overflow  out  1  sticky; a commit arrived while busy. Cleared by reset only.

Behaviour:
- Reset values: tracing=0, configId=IDLE_ID, configData=0, busy=0, commit_done=0, overflow=0. The FIFO is emptied and the state is IDLE.
- FIFO:
  - host_ready = !full.
  - A push and a pop in the same cycle are both performed; the count is unchanged. When full, a simultaneous pop does not raise host_ready in that same cycle.
  - Pointers wrap modulo FIFO_DEPTH. The count width is $clog2(FIFO_DEPTH)+1.
  - Pushes are accepted in every state, including APPLY. An entry pushed during APPLY is applied in the same commit if it is present before the FIFO goes empty.
- Outputs are registered. configId and configData return to IDLE_ID and 0 in any cycle without a pop.
- States:
  - IDLE:
    - tracing follows tracing_req with 1-cycle latency.
    - host_commit with an empty FIFO: commit_done pulses on the next cycle; stay in IDLE.
    - host_commit with a non-empty FIFO: go to QUIESCE and latch resume_req = tracing_req.
  - QUIESCE: tracing=0. Load the counter with DRAIN_CYCLES-1, then go to DRAIN.
  - DRAIN:
    - The counter decrements each cycle.
    - Any cycle with pipe_valid=1 reloads the counter.
    - At counter==0 with pipe_valid=0, go to APPLY.
  - APPLY:
    - Each cycle with the FIFO non-empty, pop one entry and drive configId/configData for exactly one cycle.
    - When the FIFO is empty, go to RESUME.
  - RESUME: tracing = resume_req AND tracing_req (current value); commit_done=1 for one cycle; go to IDLE.
- Latency: commit to first config write is at least 2+DRAIN_CYCLES cycles. N writes occupy N consecutive cycles.
- host_commit outside IDLE is ignored and sets overflow.
- tracing_req changes outside IDLE and RESUME are ignored.
- Reset mid-operation: immediate return to reset values. Partially applied writes are not replayed and pending entries are lost.

Decomposition:
- Package firmware_config_pkg holds:
  - the state enum (IDLE, QUIESCE, DRAIN, APPLY, RESUME);
  - the cfg_entry_t struct {id[7:0], data[7:0]};
  - the IDLE_ID localparam, shared with the blocks that decode configId.
- Sub-module config_fifo (parameter DEPTH, element type cfg_entry_t, push/pop/full/empty/count, async active-low reset).
- The FSM and counter live in the top.

Test Plan:
- Tracing gate: tracing_req=1 in IDLE, no commit → tracing=1 one cycle later; configId=0 throughout.
- Basic commit:
  - Stimulus: push (3,0x11), (5,0x22); tracing_req=1; pulse host_commit.
  - Required: tracing=0 on the next cycle; configId=3 with data 0x11 no earlier than DRAIN_CYCLES+2 cycles after commit; configId=5 with data 0x22 on the following cycle; then commit_done and tracing=1.
- Drain stall: pipe_valid held high for 10 cycles after commit → no config write until DRAIN_CYCLES quiet cycles after pipe_valid falls.
- Full FIFO:
  - Push 16 entries → host_ready=0; a 17th push offered is not accepted.
  - During APPLY, the next cycle after a pop reaccepts the push; 17 writes are broadcast in order.
- Empty commit and overflow:
  - Commit with an empty FIFO → commit_done next cycle; tracing is never dropped.
  - A second commit during DRAIN → overflow=1; only one commit_done.
- Reset mid-APPLY: assert rst_n=0 after 2 of 5 writes → all outputs reset at once; after release the FIFO is empty and a later commit produces no writes.

Source files
------------

// File: rtl/firmware_config_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : firmware_config_pkg
//  Description : Shared types and constants for the firmware config sequencer
//                and the pipeline blocks that decode the configId bus.
//  Revision    : 1.0  initial release
// ============================================================================
package firmware_config_pkg;

    // configId value that means "no write on the bus this cycle"
    localparam logic [7:0] IDLE_ID = 8'h00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUIESCE = 3'd1,
        DRAIN   = 3'd2,
        APPLY   = 3'd3,
        RESUME  = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] data;
    } cfg_entry_t;

endpackage : firmware_config_pkg
`default_nettype wire

// File: rtl/config_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : config_fifo
//  Description : Buffer for host config writes. Head entry is visible
//                combinationally on dout_o; full/empty come from the
//                registered count so a pop never frees space in its own cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module config_fifo
    import firmware_config_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  cfg_entry_t               din_i,
    input  logic                     pop_i,
    output cfg_entry_t               dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    cfg_entry_t    mem_q [DEPTH];

    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i  && !empty_o;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care while the entry is not counted
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule : config_fifo
`default_nettype wire

// File: rtl/firmware_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : firmware_config_sequencer
//  Description : Buffers host config writes and, on commit, drops tracing,
//                waits for the pipeline to drain, replays the writes one per
//                cycle on the configId/configData bus, then restores tracing.
//  Revision    : 1.0  initial release
// ============================================================================
module firmware_config_sequencer #(
    parameter int         FIFO_DEPTH   = 16,
    parameter int         DRAIN_CYCLES = 4,
    parameter logic [7:0] IDLE_ID      = firmware_config_pkg::IDLE_ID
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic [7:0] host_config_id,
    input  logic [7:0] host_config_data,
    input  logic       host_commit,
    input  logic       tracing_req,
    input  logic       pipe_valid,
    output logic       tracing,
    output logic [7:0] configId,
    output logic [7:0] configData,
    output logic       busy,
    output logic       commit_done,
    output logic       overflow
);

    import firmware_config_pkg::*;

    localparam int                CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam int                FCW      = $clog2(FIFO_DEPTH) + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resume_q, resume_d;
    logic             tracing_q, tracing_d;
    logic [7:0]       cfg_id_q, cfg_id_d;
    logic [7:0]       cfg_data_q, cfg_data_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;
    cfg_entry_t       fifo_din;
    cfg_entry_t       fifo_dout;

    // Writes addressed to the idle id would be invisible on the bus, so they
    // are accepted from the host but never stored.
    assign host_ready = !fifo_full;
    assign fifo_push  = host_valid && host_ready && (host_config_id != IDLE_ID);
    assign fifo_din   = '{id: host_config_id, data: host_config_data};

    config_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sequencer next-state, drain counter and registered-output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        resume_d   = resume_q;
        tracing_d  = tracing_q;
        cfg_id_d   = IDLE_ID;
        cfg_data_d = 8'h00;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        fifo_pop   = 1'b0;

        if (host_commit && (state_q != IDLE)) overflow_d = 1'b1;

        case (state_q)
            IDLE: begin
                tracing_d = tracing_req;
                if (host_commit) begin
                    if (fifo_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // Drop tracing on the very next cycle, not after QUIESCE
                        tracing_d = 1'b0;
                        resume_d  = tracing_req;
                        state_d   = QUIESCE;
                    end
                end
            end
            QUIESCE: begin
                tracing_d = 1'b0;
                cnt_d     = CNT_LOAD;
                state_d   = DRAIN;
            end
            DRAIN: begin
                tracing_d = 1'b0;
                if (pipe_valid)          cnt_d   = CNT_LOAD;
                else if (cnt_q == '0)    state_d = APPLY;
                else                     cnt_d   = cnt_q - CNT_W'(1);
            end
            APPLY: begin
                tracing_d = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cfg_id_d   = fifo_dout.id;
                    cfg_data_d = fifo_dout.data;
                end else begin
                    state_d = RESUME;
                end
            end
            RESUME: begin
                tracing_d = resume_q && tracing_req;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                tracing_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            resume_q   <= 1'b0;
            tracing_q  <= 1'b0;
            cfg_id_q   <= IDLE_ID;
            cfg_data_q <= 8'h00;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            resume_q   <= resume_d;
            tracing_q  <= tracing_d;
            cfg_id_q   <= cfg_id_d;
            cfg_data_q <= cfg_data_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign tracing     = tracing_q;
    assign configId    = cfg_id_q;
    assign configData  = cfg_data_q;
    assign busy        = (state_q != IDLE);
    assign commit_done = done_q;
    assign overflow    = overflow_q;

endmodule : firmware_config_sequencer
`default_nettype wire

// File: tb/tb_firmware_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_firmware_config_sequencer
//  Description : Self-checking bench; a queue of accepted writes predicts the
//                broadcast sequence, commit timing follows the drain rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_firmware_config_sequencer;

    localparam int         DEPTH = 16;
    localparam int         DRAIN = 4;
    localparam logic [7:0] IDLE  = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       host_valid;
    logic       host_ready;
    logic [7:0] host_config_id;
    logic [7:0] host_config_data;
    logic       host_commit;
    logic       tracing_req;
    logic       pipe_valid;
    logic       tracing;
    logic [7:0] configId;
    logic [7:0] configData;
    logic       busy;
    logic       commit_done;
    logic       overflow;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_q[$];
    logic        ovf_model = 1'b0;

    always #5 clk = ~clk;

    firmware_config_sequencer #(
        .FIFO_DEPTH   (DEPTH),
        .DRAIN_CYCLES (DRAIN),
        .IDLE_ID      (IDLE)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .host_valid       (host_valid),
        .host_ready       (host_ready),
        .host_config_id   (host_config_id),
        .host_config_data (host_config_data),
        .host_commit      (host_commit),
        .tracing_req      (tracing_req),
        .pipe_valid       (pipe_valid),
        .tracing          (tracing),
        .configId         (configId),
        .configData       (configData),
        .busy             (busy),
        .commit_done      (commit_done),
        .overflow         (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] id, input logic [7:0] data);
        bit acc;
        acc = 1'b0;
        host_valid       = 1'b1;
        host_config_id   = id;
        host_config_data = data;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = host_ready;
            step();
        end
        host_valid = 1'b0;
        chk("push_accept", 32'(acc), 1);
        if (acc && id != IDLE) model_q.push_back({id, data});
    endtask

    // Commit and follow it to completion. hold: pipe_valid high for that many
    // cycles after the commit; flip_at/recommit_at: cycle index at which
    // tracing_req toggles / a second commit is issued (0 = never).
    task automatic run_commit(input int hold, input int flip_at, input int recommit_at,
                              input bit extra_valid, input logic [7:0] extra_id,
                              input logic [7:0] extra_data);
        int          first, last, nwr, ndone, kdone, exp_first;
        bit          resume, empty_start, pend, acc;
        logic        treq_prev;
        logic [15:0] exp_e;
        first = -1; last = -1; nwr = 0; ndone = 0; kdone = -1;
        exp_first   = (DRAIN + 2 > hold + DRAIN + 1) ? DRAIN + 2 : hold + DRAIN + 1;
        empty_start = (model_q.size() == 0);
        resume      = tracing_req;
        host_commit = 1'b1;
        pipe_valid  = 1'b0;
        pend        = extra_valid;
        if (pend) begin
            host_valid       = 1'b1;
            host_config_id   = extra_id;
            host_config_data = extra_data;
        end
        if (recommit_at > 0) ovf_model = 1'b1;
        for (int k = 0; k < 300; k++) begin
            acc       = pend && host_ready;
            treq_prev = tracing_req;
            step();
            if (acc) begin
                if (extra_id != IDLE) model_q.push_back({extra_id, extra_data});
                pend       = 1'b0;
                host_valid = 1'b0;
            end
            if (configId !== IDLE) begin
                nwr++;
                if (model_q.size() == 0) begin
                    chk("unexpected_write", 32'(configId), 32'(IDLE));
                end else begin
                    exp_e = model_q.pop_front();
                    chk("write_id", 32'(configId), 32'(exp_e[15:8]));
                    chk("write_data", 32'(configData), 32'(exp_e[7:0]));
                end
                if (first < 0) begin
                    first = k;
                    chk("first_write_latency", k, exp_first);
                end else begin
                    chk("write_back_to_back", k, last + 1);
                end
                last = k;
            end else begin
                chk("idle_data_zero", 32'(configData), 0);
            end
            if (commit_done === 1'b1) begin
                ndone++;
                if (kdone < 0) begin
                    kdone = k;
                    chk("resume_tracing", 32'(tracing), 32'(resume & treq_prev));
                end
            end else if (!empty_start && kdone < 0) begin
                chk("tracing_dropped", 32'(tracing), 0);
                chk("busy_in_commit", 32'(busy), 1);
            end
            if (empty_start && k == 0) begin
                chk("empty_commit_tracing", 32'(tracing), 32'(resume));
                chk("empty_commit_busy", 32'(busy), 0);
            end
            if (kdone >= 0 && k >= kdone + 3) break;
            host_commit = (k + 1 == recommit_at);
            pipe_valid  = (k + 1 <= hold);
            if (k + 1 == flip_at) tracing_req = ~tracing_req;
        end
        host_commit = 1'b0;
        pipe_valid  = 1'b0;
        host_valid  = 1'b0;
        chk("commit_done_count", ndone, 1);
        chk("model_drained", model_q.size(), 0);
        if (empty_start) begin
            chk("empty_done_cycle", kdone, 0);
            chk("empty_no_writes", nwr, 0);
        end else begin
            chk("done_after_last_write", kdone, last + 2);
        end
        chk("overflow_flag", 32'(overflow), 32'(ovf_model));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, nwr;
        logic [7:0]  rid, rdat;
        logic [15:0] exp_e;

        rst_n = 1'b0; host_valid = 1'b0; host_config_id = 8'h00; host_config_data = 8'h00;
        host_commit = 1'b0; tracing_req = 1'b0; pipe_valid = 1'b0;
        step(); step();
        chk("rst_tracing", 32'(tracing), 0);
        chk("rst_configId", 32'(configId), 32'(IDLE));
        chk("rst_configData", 32'(configData), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_commit_done", 32'(commit_done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_host_ready", 32'(host_ready), 1);
        rst_n = 1'b1;
        step();

        // Tracing gate in IDLE
        tracing_req = 1'b1;
        chk("gate_before", 32'(tracing), 0);
        step();
        chk("gate_on", 32'(tracing), 1);
        chk("gate_configId", 32'(configId), 32'(IDLE));
        tracing_req = 1'b0;
        step();
        chk("gate_off", 32'(tracing), 0);

        // Basic commit
        push(8'd3, 8'h11);
        push(8'd5, 8'h22);
        tracing_req = 1'b1;
        step();
        run_commit(0, 0, 0, 1'b0, 8'h00, 8'h00);

        // Drain stall, including an idle-id write that must be dropped
        push(8'd9, 8'h33);
        push(IDLE, 8'h44);
        push(8'h21, 8'h55);
        run_commit(10, 0, 0, 1'b0, 8'h00, 8'h00);

        // Full FIFO, refused push, then a push accepted during APPLY
        for (int i = 0; i < DEPTH; i++) push(8'(i + 1), 8'($urandom_range(0, 255)));
        chk("full_not_ready", 32'(host_ready), 0);
        host_valid = 1'b1; host_config_id = 8'hEE; host_config_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_stays_full", 32'(host_ready), 0);
        end
        host_valid = 1'b0;
        run_commit(0, 0, 0, 1'b1, 8'h77, 8'h99);

        // Empty commit, then a second commit during DRAIN
        tracing_req = 1'b1;
        step();
        run_commit(0, 0, 0, 1'b0, 8'h00, 8'h00);
        push(8'h42, 8'h01);
        run_commit(0, 0, 3, 1'b0, 8'h00, 8'h00);

        // Randomized commits
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 10);
            for (int j = 0; j < n; j++) begin
                rid  = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 5) == 0) rid = IDLE;
                rdat = 8'($urandom_range(0, 255));
                push(rid, rdat);
            end
            tracing_req = 1'($urandom_range(0, 1));
            step();
            if (model_q.size() == 0)
                run_commit(0, 0, 0, 1'b0, 8'h00, 8'h00);
            else
                run_commit($urandom_range(0, 12), ($urandom_range(0, 1) == 1) ? 3 : 0, 0,
                           1'b0, 8'h00, 8'h00);
        end

        // Reset in the middle of APPLY
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 8'(8'hA0 + i));
        tracing_req = 1'b1;
        step();
        host_commit = 1'b1;
        step();
        host_commit = 1'b0;
        nwr = 0;
        for (int k = 0; k < 100 && nwr < 2; k++) begin
            step();
            if (configId !== IDLE) begin
                nwr++;
                exp_e = model_q.pop_front();
                chk("rst_test_write", 32'({configId, configData}), 32'(exp_e));
            end
        end
        chk("rst_test_writes_seen", nwr, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_tracing", 32'(tracing), 0);
        chk("midrst_configId", 32'(configId), 32'(IDLE));
        chk("midrst_configData", 32'(configData), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_commit_done", 32'(commit_done), 0);
        chk("midrst_overflow", 32'(overflow), 0);
        chk("midrst_host_ready", 32'(host_ready), 1);
        model_q.delete();
        ovf_model = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 0);
        run_commit(0, 0, 0, 1'b0, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_firmware_config_sequencer
`default_nettype wire
